// File: rtl/plot_fb_writer.sv
// Pixel-plot receiver for the shape drawers. It queues plot strobes, range-checks them
// and writes them to a stallable 160x120x3 framebuffer port, with a built-in full-screen fill.
module plot_fb_writer #(
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 120,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  vga_x,
    input  logic [6:0]  vga_y,
    input  logic [2:0]  vga_colour,
    input  logic        vga_plot,
    input  logic        clear_start,
    input  logic [2:0]  clear_colour,
    input  logic        fb_wait,
    output logic [14:0] fb_addr,
    output logic [2:0]  fb_wrdata,
    output logic        fb_we,
    output logic        busy,
    output logic        clear_done,
    output logic        overflow,
    output logic [7:0]  oob_count
);

    localparam int          PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [14:0] LAST_ADDR = 15'(SCREEN_W * SCREEN_H - 1);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CLEAR,
        FINISH
    } state_t;

    state_t          state_q, state_d;
    logic [17:0]     fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]  rd_ptr_q, rd_ptr_d;
    logic [14:0]     fb_addr_q, fb_addr_d;
    logic [2:0]      fb_wrdata_q, fb_wrdata_d;
    logic            fb_we_q, fb_we_d;
    logic            clear_done_q, clear_done_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      oob_q, oob_d;
    logic [14:0]     clr_cnt_q, clr_cnt_d;
    logic [2:0]      clr_colour_q, clr_colour_d;

    logic            fifo_empty;
    logic            fifo_full;
    logic            in_range;
    logic            reg_free;
    logic            push;
    logic            pop;
    logic [14:0]     y_ext;
    logic [14:0]     plot_addr;
    logic [17:0]     head_entry;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign in_range   = ({1'b0, vga_x} < 9'(SCREEN_W)) && ({1'b0, vga_y} < 8'(SCREEN_H));
    assign reg_free   = !fb_we_q || !fb_wait;
    assign head_entry = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

    // y*160 as shift-and-add; the address is converted once, at push time
    assign y_ext     = {8'b0, vga_y};
    assign plot_addr = (y_ext << 7) + (y_ext << 5) + {7'b0, vga_x};

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fb_addr_d    = fb_addr_q;
        fb_wrdata_d  = fb_wrdata_q;
        fb_we_d      = fb_we_q;
        clear_done_d = 1'b0;
        overflow_d   = overflow_q;
        oob_d        = oob_q;
        clr_cnt_d    = clr_cnt_q;
        clr_colour_d = clr_colour_q;
        push         = 1'b0;
        pop          = 1'b0;

        if (reg_free) begin
            fb_we_d = 1'b0;
        end

        if (vga_plot) begin
            if (!in_range) begin
                if (oob_q != 8'hFF) begin
                    oob_d = oob_q + 8'd1;
                end
            end else if (!fifo_full) begin
                push = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                pop = reg_free && !fifo_empty;
                if (clear_start) begin
                    clr_colour_d = clear_colour;
                    state_d      = DRAIN;
                end
            end
            DRAIN: begin
                pop = reg_free && !fifo_empty;
                if (reg_free && fifo_empty) begin
                    clr_cnt_d = '0;
                    state_d   = CLEAR;
                end
            end
            CLEAR: begin
                if (reg_free) begin
                    fb_addr_d   = clr_cnt_q;
                    fb_wrdata_d = clr_colour_q;
                    fb_we_d     = 1'b1;
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_d = FINISH;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 15'd1;
                    end
                end
            end
            FINISH: begin
                // Register only frees up once the final fill pixel has been taken
                if (reg_free) begin
                    clear_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pop) begin
            fb_addr_d   = head_entry[17:3];
            fb_wrdata_d = head_entry[2:0];
            fb_we_d     = 1'b1;
            rd_ptr_d    = rd_ptr_q + PTR_ONE;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fb_addr_q    <= '0;
            fb_wrdata_q  <= '0;
            fb_we_q      <= 1'b0;
            clear_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            oob_q        <= '0;
            clr_cnt_q    <= '0;
            clr_colour_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fb_addr_q    <= fb_addr_d;
            fb_wrdata_q  <= fb_wrdata_d;
            fb_we_q      <= fb_we_d;
            clear_done_q <= clear_done_d;
            overflow_q   <= overflow_d;
            oob_q        <= oob_d;
            clr_cnt_q    <= clr_cnt_d;
            clr_colour_q <= clr_colour_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are valid
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= {plot_addr, vga_colour};
        end
    end

    assign fb_addr    = fb_addr_q;
    assign fb_wrdata  = fb_wrdata_q;
    assign fb_we      = fb_we_q;
    assign clear_done = clear_done_q;
    assign overflow   = overflow_q;
    assign oob_count  = oob_q;
    assign busy       = !fifo_empty || fb_we_q || (state_q != IDLE);

endmodule

// File: tb/tb_plot_fb_writer.sv
// Scoreboard bench for plot_fb_writer: expected writes are queued as stimulus is issued
// and a negedge monitor pops them whenever the framebuffer port completes a write.
module tb_plot_fb_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        clear_start;
    logic [2:0]  clear_colour;
    logic        fb_wait;
    logic [14:0] fb_addr;
    logic [2:0]  fb_wrdata;
    logic        fb_we;
    logic        busy;
    logic        clear_done;
    logic        overflow;
    logic [7:0]  oob_count;

    int          errors = 0;
    int          checks = 0;
    int          write_count = 0;
    int          cyc = 0;
    logic [17:0] exp_q [$];

    plot_fb_writer dut (
        .clk          (clk),
        .rst          (rst),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .vga_plot     (vga_plot),
        .clear_start  (clear_start),
        .clear_colour (clear_colour),
        .fb_wait      (fb_wait),
        .fb_addr      (fb_addr),
        .fb_wrdata    (fb_wrdata),
        .fb_we        (fb_we),
        .busy         (busy),
        .clear_done   (clear_done),
        .overflow     (overflow),
        .oob_count    (oob_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic plot, input logic [7:0] x, input logic [6:0] y,
                                 input logic [2:0] c);
        vga_plot   = plot;
        vga_x      = x;
        vga_y      = y;
        vga_colour = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'd0, 7'd0, 3'd0);
    endtask

    // Every completed write must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (fb_we === 1'b1 && fb_wait === 1'b0) begin
            write_count++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_write_addr", {17'd0, fb_addr}, 32'hFFFF_FFFF);
            end else begin
                checkOutput("write_addr_data", {14'd0, fb_addr, fb_wrdata}, {14'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        int  snap;
        int  first_cyc;
        int  last_cyc;
        int  done_cyc;
        int  done_pulses;
        int  busy_low;
        int  fill_writes;
        bit  done_seen;
        bit  found;

        rst          = 1'b1;
        vga_plot     = 1'b0;
        vga_x        = '0;
        vga_y        = '0;
        vga_colour   = '0;
        clear_start  = 1'b0;
        clear_colour = '0;
        fb_wait      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_fb_we", fb_we, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_clear_done", clear_done, 0);
        checkOutput("reset_overflow", overflow, 0);
        checkOutput("reset_oob", oob_count, 0);
        checkOutput("reset_addr", fb_addr, 0);
        rst = 1'b0;
        idle(2);

        $display("[TB] single plot");
        exp_q.push_back({15'd485, 3'b010});
        applyStimulus(1'b1, 8'd5, 7'd3, 3'b010);
        vga_plot = 1'b0;
        checkOutput("t1_we_cycle1", fb_we, 0);
        checkOutput("t1_busy_cycle1", busy, 1);
        idle(1);
        checkOutput("t1_we_cycle2", fb_we, 1);
        checkOutput("t1_addr", fb_addr, 485);
        checkOutput("t1_data", fb_wrdata, 3'b010);
        idle(1);
        checkOutput("t1_we_after", fb_we, 0);
        checkOutput("t1_busy_after", busy, 0);

        $display("[TB] out-of-range plots");
        snap = write_count;
        applyStimulus(1'b1, 8'd160, 7'd0, 3'd1);
        applyStimulus(1'b1, 8'd0, 7'd120, 3'd1);
        idle(4);
        checkOutput("t2_oob_two", oob_count, 2);
        checkOutput("t2_overflow", overflow, 0);
        checkOutput("t2_no_writes", write_count - snap, 0);
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, 8'd200, 7'd127, 3'd7);
        idle(3);
        checkOutput("t2_oob_saturate", oob_count, 255);
        checkOutput("t2_no_writes_bulk", write_count - snap, 0);

        $display("[TB] backpressure");
        fb_wait = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) exp_q.push_back({15'(i), 3'(i)});
            applyStimulus(1'b1, 8'(i), 7'd0, 3'(i));
        end
        vga_plot = 1'b0;
        checkOutput("t3_overflow", overflow, 1);
        checkOutput("t3_held_addr", fb_addr, 0);
        fb_wait = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checkOutput("t3_stream_we", fb_we, 1);
            checkOutput("t3_stream_addr", fb_addr, k);
            idle(1);
        end
        checkOutput("t3_stream_end", fb_we, 0);
        checkOutput("t3_queue_drained", exp_q.size(), 0);

        $display("[TB] corner pixel");
        exp_q.push_back({15'd19199, 3'b111});
        applyStimulus(1'b1, 8'd159, 7'd119, 3'b111);
        idle(1);
        checkOutput("t4_we", fb_we, 1);
        checkOutput("t4_addr", fb_addr, 19199);
        checkOutput("t4_data", fb_wrdata, 3'b111);
        idle(2);

        $display("[TB] full clear");
        for (int i = 0; i < 19200; i++) exp_q.push_back({15'(i), 3'b100});
        clear_start  = 1'b1;
        clear_colour = 3'b100;
        idle(1);
        clear_start  = 1'b0;
        clear_colour = 3'b000;
        first_cyc = -1; last_cyc = -1; done_cyc = -1;
        done_pulses = 0; busy_low = 0; fill_writes = 0; done_seen = 0;
        for (int k = 0; k < 21000; k++) begin
            if (clear_done) begin
                done_pulses++;
                if (!done_seen) done_cyc = cyc;
                done_seen = 1'b1;
            end
            if (!done_seen) begin
                if (!busy) busy_low++;
                if (fb_we && !fb_wait) begin
                    fill_writes++;
                    if (first_cyc < 0) first_cyc = cyc;
                    if (fb_addr == 15'd19199 && fb_wrdata == 3'b100) last_cyc = cyc;
                end
            end
            if (done_seen && exp_q.size() == 0 && cyc > done_cyc + 4) break;
            if (k == 100) begin
                exp_q.push_back({15'd161, 3'b011});
                applyStimulus(1'b1, 8'd1, 7'd1, 3'b011);
            end else if (k == 200) begin
                clear_start  = 1'b1;
                clear_colour = 3'b001;
                idle(1);
                clear_start  = 1'b0;
            end else begin
                idle(1);
            end
        end
        checkOutput("t5_done_seen", done_seen, 1);
        checkOutput("t5_fill_writes", fill_writes, 19200);
        checkOutput("t5_consecutive", last_cyc - first_cyc, 19199);
        checkOutput("t5_done_timing", done_cyc - last_cyc, 1);
        checkOutput("t5_done_pulses", done_pulses, 1);
        checkOutput("t5_busy_low", busy_low, 0);
        checkOutput("t5_queue_drained", exp_q.size(), 0);
        idle(3);

        $display("[TB] reset mid-clear");
        for (int i = 0; i < 19200; i++) exp_q.push_back({15'(i), 3'b101});
        clear_start  = 1'b1;
        clear_colour = 3'b101;
        idle(1);
        clear_start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 6000 && !found; k++) begin
            if (fb_we && fb_addr == 15'd5000) found = 1'b1;
            else idle(1);
        end
        checkOutput("t6_reached_5000", found, 1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        exp_q.delete();
        snap = write_count;
        checkOutput("t6_we", fb_we, 0);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_clear_done", clear_done, 0);
        checkOutput("t6_oob", oob_count, 0);
        checkOutput("t6_overflow", overflow, 0);
        idle(5);
        checkOutput("t6_no_writes", write_count - snap, 0);
        exp_q.push_back({15'd2, 3'b110});
        applyStimulus(1'b1, 8'd2, 7'd0, 3'b110);
        idle(1);
        checkOutput("t6_plot_we", fb_we, 1);
        checkOutput("t6_plot_addr", fb_addr, 2);
        idle(1);
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) idle(1);
        checkOutput("final_queue_empty", exp_q.size(), 0);
        idle(20);
        checkOutput("final_writes_after_reset", write_count - snap, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/plot_fb_writer.md
Name: plot_fb_writer

Overview:
- Receiving end of the pixel-plot interface that the shape drawers (circle, reuleaux) drive: vga_x / vga_y / vga_colour / vga_plot.
- Buffers plot strobes in a small FIFO, range-checks them and converts each one to a linear framebuffer address.
- Issues single-pixel writes to a 160x120x3 framebuffer memory port that may stall.
- Also provides a full-screen clear engine, so drawers never need to sweep the screen themselves.

Parameters:
- SCREEN_W, 160, visible width in pixels; x must be < SCREEN_W.
- SCREEN_H, 120, visible height in pixels; y must be < SCREEN_H.
- FIFO_DEPTH, 4, plot FIFO entries (power of two, >= 2).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active high.
- vga_x  in  8  plot x coordinate.
- vga_y  in  7  plot y coordinate.
- vga_colour  in  3  plot colour.
- vga_plot  in  1  plot strobe; one pixel per cycle high.
- clear_start  in  1  request a full-screen fill.
- clear_colour  in  3  fill colour, sampled on the clear_start acceptance cycle.
- fb_wait  in  1  memory stall; write not taken while high.
- fb_addr  out  15  linear pixel address, y*SCREEN_W + x.
- fb_wrdata  out  3  pixel colour.
- fb_we  out  1  write request.
- busy  out  1  high when the FIFO is non-empty, fb_we is high, or the FSM is not IDLE.
- clear_done  out  1  one-cycle pulse when a fill completes.
- overflow  out  1  sticky; set when an in-range plot is dropped because the FIFO is full.
- oob_count  out  8  saturating count of out-of-range plots.

Behaviour:
- Reset: all outputs 0, FIFO empty, oob_count 0, overflow 0, FSM in IDLE. A reset asserted mid-operation aborts immediately: no further writes and no clear_done.
- Input acceptance:
  - A cycle with vga_plot=1 and x>=SCREEN_W or y>=SCREEN_H is discarded and increments oob_count, saturating at 255.
  - An in-range plot is pushed when the FIFO is not full at the start of the cycle. Otherwise it is dropped and overflow is set.
  - Plots are accepted in every FSM state, including during a clear.
- Address: fb_addr = (y<<7)+(y<<5)+x, computed at push or pop time. Maximum address is 19199.
- Output register (fb_addr/fb_wrdata/fb_we):
  - A write completes on any cycle with fb_we=1 and fb_wait=0.
  - While fb_we=1 and fb_wait=1, all three outputs hold unchanged.
  - The register is free when fb_we=0 or the current write completes this cycle.
- FSM states: IDLE, DRAIN, CLEAR, FINISH.
  - IDLE:
    - If the register is free and the FIFO is non-empty, pop into the register. fb_we=1 on the next cycle, so minimum plot-to-write latency is 2 cycles.
    - clear_start=1: latch clear_colour and go to DRAIN. clear_start is ignored in all other states.
  - DRAIN:
    - Keep popping the FIFO as in IDLE.
    - Go to CLEAR when the FIFO is empty and the register is free.
  - CLEAR:
    - Counter starts at 0 and loads (counter, latched colour) into the register each cycle the register is free.
    - FIFO is not popped; incoming plots accumulate and may overflow.
    - After address SCREEN_W*SCREEN_H-1 is loaded, go to FINISH.
  - FINISH:
    - Wait for that last write to complete.
    - Pulse clear_done for one cycle, then return to IDLE and resume draining the FIFO.
- Ordering: plot writes are issued in acceptance order. Pre-clear plots are written before the fill; plots accepted during the clear are written after it.
- Throughput: with fb_wait=0, one write per cycle sustained.
- Effective buffering: FIFO_DEPTH entries plus the output register.
- Simultaneous push and pop on an empty FIFO is legal; the fall-through still costs the 1-cycle register stage.

Test Plan:
1. Single plot: x=5, y=3, colour 010, fb_wait=0 -> exactly 2 cycles later fb_we=1 for one cycle, fb_addr=485, fb_wrdata=010; busy drops the following cycle.
2. Out-of-range plots: x=160,y=0 then x=0,y=120 -> no fb_we ever, oob_count=2, overflow=0. Then 300 such plots -> oob_count=255.
3. Backpressure: fb_wait=1, six consecutive plots to (0,0)..(5,0) -> first five retained, sixth dropped, overflow=1. Release fb_wait -> writes to addresses 0,1,2,3,4 on consecutive cycles; address 5 never written.
4. Corner pixel: x=159, y=119, colour 111 -> fb_addr=19199, fb_wrdata=111.
5. Full clear: clear_start with clear_colour=100 and fb_wait=0 -> 19200 consecutive writes, addresses 0..19199, all data 100. clear_done high exactly one cycle after the last write, busy high throughout. A plot (1,1) injected mid-clear is written to address 161 after the fill. A second clear_start during the fill is ignored.
6. Reset mid-clear: rst asserted around address 5000 -> the next cycle has fb_we=0, busy=0, clear_done=0, oob_count=0. A subsequent plot (2,0) is written to address 2 normally.
